// File: rtl/led_matrix_pkg.sv
// Frame layout constants shared by the frame writer and the HUB75 panel driver.
// Both ends must agree on bank size, pixel width and RGB444 field placement.
package led_matrix_pkg;

    localparam int COLS          = 48;
    localparam int ROWS_PER_BANK = 32;
    localparam int PIX_W         = 12;
    localparam int ADDR_W        = 12;
    localparam int R_OFS         = 8;
    localparam int G_OFS         = 4;
    localparam int B_OFS         = 0;
    localparam int BANK_SIZE     = COLS * ROWS_PER_BANK;

    typedef enum logic [2:0] {
        S_IDLE,
        S_B0,
        S_B1,
        S_B2,
        S_DONE
    } wr_state_t;

    function automatic logic [PIX_W-1:0] pack_rgb(input logic [3:0] r,
                                                  input logic [3:0] g,
                                                  input logic [3:0] b);
        logic [PIX_W-1:0] p;
        p = '0;
        p[R_OFS +: 4] = r;
        p[G_OFS +: 4] = g;
        p[B_OFS +: 4] = b;
        return p;
    endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Linear frame-buffer address counter with a bank bit (0 = upper half, 1 = lower).
// o_last flags the final pixel of the lower bank; advancing past it wraps back to bank 0, addr 0.
module fb_addr_gen
    import led_matrix_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_adv,
    input  logic              i_clr,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_bank,
    output logic              o_last
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(BANK_SIZE - 1);

    logic wrap;

    assign wrap   = (o_addr == ADDR_MAX);
    assign o_last = o_bank && wrap;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            o_addr <= '0;
            o_bank <= 1'b0;
        end else if (i_adv) begin
            if (wrap) begin
                o_addr <= '0;
                o_bank <= ~o_bank;
            end else begin
                o_addr <= o_addr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_frame_writer.sv
// Unpacks a byte stream of RGB444 pixel pairs (3 bytes -> 2 pixels) and writes them
// into the two frame-buffer banks. All outputs are registered; one write per accepted byte at most.
module led_frame_writer
    import led_matrix_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [7:0]        i_data,
    input  logic              i_valid,
    input  logic              i_sof,
    output logic              o_ready,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [PIX_W-1:0]  o_ram_data,
    output logic              o_ram_b1_we,
    output logic              o_ram_b2_we,
    output logic              o_frame_done,
    output logic              o_sync_err
);

    wr_state_t         state;
    logic [7:0]        byte0;
    logic [3:0]        r1_nib;
    logic              accept;
    logic              adv;
    logic              clr;
    logic [ADDR_W-1:0] cur_addr;
    logic              cur_bank;
    logic              cur_last;
    logic [PIX_W-1:0]  pix0;
    logic [PIX_W-1:0]  pix1;

    assign accept = i_valid && o_ready;

    always_comb begin
        clr  = accept && i_sof;
        adv  = accept && !i_sof && (state == S_B1 || state == S_B2);
        pix0 = pack_rgb(byte0[7:4], byte0[3:0], i_data[7:4]);
        pix1 = pack_rgb(r1_nib, i_data[7:4], i_data[3:0]);
    end

    fb_addr_gen u_addr (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_adv  (adv),
        .i_clr  (clr),
        .o_addr (cur_addr),
        .o_bank (cur_bank),
        .o_last (cur_last)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= S_IDLE;
            byte0        <= '0;
            r1_nib       <= '0;
            o_ready      <= 1'b1;
            o_ram_addr   <= '0;
            o_ram_data   <= '0;
            o_ram_b1_we  <= 1'b0;
            o_ram_b2_we  <= 1'b0;
            o_frame_done <= 1'b0;
            o_sync_err   <= 1'b0;
        end else begin
            o_ram_b1_we  <= 1'b0;
            o_ram_b2_we  <= 1'b0;
            o_frame_done <= 1'b0;
            o_sync_err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Without SOF the byte is swallowed so the host can't desync us.
                    if (accept && i_sof) begin
                        byte0 <= i_data;
                        state <= S_B1;
                    end
                end
                S_B0, S_B1, S_B2: begin
                    if (accept) begin
                        if (i_sof) begin
                            // Restart: any half-built pixel is dropped unwritten.
                            o_sync_err <= 1'b1;
                            byte0      <= i_data;
                            state      <= S_B1;
                        end else if (state == S_B0) begin
                            byte0 <= i_data;
                            state <= S_B1;
                        end else if (state == S_B1) begin
                            o_ram_addr  <= cur_addr;
                            o_ram_data  <= pix0;
                            o_ram_b1_we <= ~cur_bank;
                            o_ram_b2_we <= cur_bank;
                            r1_nib      <= i_data[3:0];
                            state       <= S_B2;
                        end else begin
                            o_ram_addr  <= cur_addr;
                            o_ram_data  <= pix1;
                            o_ram_b1_we <= ~cur_bank;
                            o_ram_b2_we <= cur_bank;
                            if (cur_last) begin
                                o_frame_done <= 1'b1;
                                o_ready      <= 1'b0;
                                state        <= S_DONE;
                            end else begin
                                state <= S_B0;
                            end
                        end
                    end
                end
                S_DONE: begin
                    o_ready <= 1'b1;
                    state   <= S_IDLE;
                end
                default: begin
                    o_ready <= 1'b1;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_frame_writer.sv
// Bench for led_frame_writer: byte-index frame model checked every cycle, plus literal pins.
module tb_led_frame_writer;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [7:0]  i_data;
    logic        i_valid;
    logic        i_sof;
    logic        o_ready;
    logic [11:0] o_ram_addr;
    logic [11:0] o_ram_data;
    logic        o_ram_b1_we;
    logic        o_ram_b2_we;
    logic        o_frame_done;
    logic        o_sync_err;

    led_frame_writer dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_data       (i_data),
        .i_valid      (i_valid),
        .i_sof        (i_sof),
        .o_ready      (o_ready),
        .o_ram_addr   (o_ram_addr),
        .o_ram_data   (o_ram_data),
        .o_ram_b1_we  (o_ram_b1_we),
        .o_ram_b2_we  (o_ram_b2_we),
        .o_frame_done (o_frame_done),
        .o_sync_err   (o_sync_err)
    );

    always #5 i_clk = ~i_clk;

    localparam int BANK  = 1536;
    localparam int FBYTES = 4608;

    int errs   = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: tracks byte index within the current frame; pixel index follows from it.
    logic        m_ready, e_we1, e_we2, e_done, e_err;
    logic [11:0] e_addr, e_data;
    bit          in_frame;
    int          k, ph, p;
    logic [7:0]  trip [3];

    always @(posedge i_clk) begin
        if (i_rst) begin
            m_ready = 1'b1; e_we1 = 0; e_we2 = 0; e_done = 0; e_err = 0;
            e_addr = '0; e_data = '0; in_frame = 0; k = 0;
        end else begin
            e_we1 = 0; e_we2 = 0; e_done = 0; e_err = 0;
            if (i_valid && m_ready) begin
                m_ready = 1'b1;
                if (i_sof) begin
                    e_err    = in_frame;
                    in_frame = 1;
                    trip[0]  = i_data;
                    k        = 1;
                end else if (in_frame) begin
                    ph = k % 3;
                    trip[ph] = i_data;
                    if (ph != 0) begin
                        p      = (k / 3) * 2 + ph - 1;
                        e_addr = 12'(p % BANK);
                        e_we1  = (p < BANK);
                        e_we2  = (p >= BANK);
                        e_data = (ph == 1) ? {trip[0], i_data[7:4]} : {trip[1][3:0], i_data};
                    end
                    k++;
                    if (k == FBYTES) begin
                        in_frame = 0;
                        e_done   = 1;
                        m_ready  = 1'b0;
                    end
                end
            end else begin
                m_ready = 1'b1;
            end
        end
    end

    logic        lg_bank [$];
    logic [11:0] lg_addr [$];
    logic [11:0] lg_data [$];
    int rdy_low, done_cnt, err_cnt;
    bit done_at_last;

    always @(negedge i_clk) begin
        if (chk_en) begin
            chk("ready", o_ready, m_ready);
            chk("b1_we", o_ram_b1_we, e_we1);
            chk("b2_we", o_ram_b2_we, e_we2);
            chk("frame_done", o_frame_done, e_done);
            chk("sync_err", o_sync_err, e_err);
            if (e_we1 || e_we2) begin
                chk("addr", o_ram_addr, e_addr);
                chk("data", o_ram_data, e_data);
            end
            if (o_ram_b1_we || o_ram_b2_we) begin
                lg_bank.push_back(o_ram_b2_we);
                lg_addr.push_back(o_ram_addr);
                lg_data.push_back(o_ram_data);
            end
            if (!o_ready) rdy_low++;
            if (o_sync_err) err_cnt++;
            if (o_frame_done) begin
                done_cnt++;
                done_at_last = o_ram_b2_we && (o_ram_addr == 12'd1535);
            end
        end
    end

    task automatic clear_log();
        lg_bank.delete(); lg_addr.delete(); lg_data.delete();
        rdy_low = 0; done_cnt = 0; err_cnt = 0; done_at_last = 0;
    endtask

    task automatic send(input logic [7:0] d, input logic s);
        logic r;
        i_data = d; i_valid = 1'b1; i_sof = s;
        for (int n = 0; n < 8; n++) begin
            r = o_ready;
            @(negedge i_clk);
            if (r) return;
        end
        checks++; errs++;
        $display("FAIL send_timeout: byte %0h not accepted within 8 cycles", d);
    endtask

    task automatic idle(input int n);
        i_valid = 1'b0; i_sof = 1'b0;
        repeat (n) @(negedge i_clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, o_ready, 1'b1);
        chk({tag, "_addr"}, o_ram_addr, 12'h000);
        chk({tag, "_data"}, o_ram_data, 12'h000);
        chk({tag, "_b1_we"}, o_ram_b1_we, 1'b0);
        chk({tag, "_b2_we"}, o_ram_b2_we, 1'b0);
        chk({tag, "_done"}, o_frame_done, 1'b0);
        chk({tag, "_err"}, o_sync_err, 1'b0);
    endtask

    function automatic logic [7:0] fbyte(input int i);
        return 8'((i * 7 + 3) & 255);
    endfunction

    logic        ref_bank [$];
    logic [11:0] ref_addr [$];
    logic [11:0] ref_data [$];

    initial begin
        int b1c, mism;
        i_rst = 1'b1; i_valid = 1'b0; i_sof = 1'b0; i_data = '0;
        clear_log();
        repeat (3) @(negedge i_clk);
        chk_reset_vals("rst0");
        i_rst  = 1'b0;
        chk_en = 1'b1;

        // bytes outside a frame are dropped
        for (int i = 0; i < 5; i++) send(8'(8'h10 + i), 1'b0);
        idle(2);
        chk("idle_writes", lg_addr.size(), 0);
        chk("idle_ready_low", rdy_low, 0);

        // hand-computed packing
        send(8'hAB, 1'b1); send(8'hCD, 1'b0); send(8'hEF, 1'b0);
        idle(2);
        chk("pk_count", lg_addr.size(), 2);
        chk("pk0_data", lg_data[0], 12'hABC);
        chk("pk0_addr", lg_addr[0], 12'd0);
        chk("pk0_bank", lg_bank[0], 1'b0);
        chk("pk1_data", lg_data[1], 12'hDEF);
        chk("pk1_addr", lg_addr[1], 12'd1);

        // continue to 101 bytes, then SOF lands on the B2 phase
        for (int i = 3; i <= 100; i++) send(fbyte(i), 1'b0);
        idle(1);
        chk("pre_sync_writes", lg_addr.size(), 67);
        clear_log();

        for (int i = 0; i < FBYTES; i++) send(fbyte(i), i == 0);
        idle(3);
        chk("sync_err_pulses", err_cnt, 1);
        chk("ff_writes", lg_addr.size(), 3072);
        b1c = 0;
        foreach (lg_bank[i]) if (!lg_bank[i]) b1c++;
        chk("ff_b1_writes", b1c, 1536);
        chk("ff_first_bank", lg_bank[0], 1'b0);
        chk("ff_first_addr", lg_addr[0], 12'd0);
        chk("ff_1535_bank", lg_bank[1535], 1'b0);
        chk("ff_1535_addr", lg_addr[1535], 12'd1535);
        chk("ff_1536_bank", lg_bank[1536], 1'b1);
        chk("ff_1536_addr", lg_addr[1536], 12'd0);
        chk("ff_last_addr", lg_addr[3071], 12'd1535);
        chk("ff_done_pulses", done_cnt, 1);
        chk("ff_done_at_last", done_at_last, 1'b1);
        chk("ff_ready_low", rdy_low, 1);
        ref_bank = lg_bank; ref_addr = lg_addr; ref_data = lg_data;

        // reset mid-frame
        clear_log();
        for (int i = 0; i < 2000; i++) send(fbyte(i), i == 0);
        i_valid = 1'b0; i_sof = 1'b0; i_rst = 1'b1;
        @(negedge i_clk);
        chk_reset_vals("rst_mid");
        i_rst = 1'b0;
        idle(2);

        // same frame with random valid gaps must match the back-to-back run
        clear_log();
        for (int i = 0; i < FBYTES; i++) begin
            send(fbyte(i), i == 0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(3);
        chk("gap_writes", lg_addr.size(), 3072);
        mism = 0;
        if (lg_addr.size() == ref_addr.size())
            foreach (lg_addr[i])
                if (lg_addr[i] !== ref_addr[i] || lg_data[i] !== ref_data[i] || lg_bank[i] !== ref_bank[i])
                    mism++;
        chk("gap_vs_b2b_diffs", mism, 0);
        chk("gap_first_addr", lg_addr[0], 12'd0);
        chk("gap_first_bank", lg_bank[0], 1'b0);
        chk("gap_done_pulses", done_cnt, 1);
        chk("gap_sync_err", err_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/led_frame_writer.md
# led_frame_writer

Write-side counterpart of the HUB75 panel driver. It accepts a byte stream of packed RGB444 pixels through a valid/ready handshake and writes the pixels into the two frame-buffer banks the driver scans: bank 1 for the upper half-panel, bank 2 for the lower. It sits between the host link (UART/SPI byte receiver) and the dual-bank frame RAM write ports.

## Interface
- `COLS`, 48: pixels per row.
- `ROWS_PER_BANK`, 32: rows held in each bank (panel height = 2×).
- `ADDR_W`, 12: RAM address width.
- `PIX_W`, 12: pixel width. Fields: R[11:8], G[7:4], B[3:0].

Ports:
- `i_clk`  in  1  system clock; all logic on rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_data`  in  8  stream byte.
- `i_valid`  in  1  `i_data` valid.
- `i_sof`  in  1  qualifies the current byte as the first byte of a frame; sampled only with `i_valid`.
- `o_ready`  out  1  byte accepted when `i_valid && o_ready`.
- `o_ram_addr`  out  ADDR_W  write address within the bank.
- `o_ram_data`  out  PIX_W  pixel to write.
- `o_ram_b1_we`  out  1  write strobe, bank 1.
- `o_ram_b2_we`  out  1  write strobe, bank 2.
- `o_frame_done`  out  1  one-cycle pulse after the last pixel of a frame is written.
- `o_sync_err`  out  1  one-cycle pulse when SOF arrives mid-frame.

## Operation
- Packing: 3 bytes carry 2 pixels. byte0 = {R0,G0}, byte1 = {B0,R1}, byte2 = {G1,B1}. Pixel 0 is written on acceptance of byte1 and pixel 1 on acceptance of byte2. This gives at most one write per accepted byte, so there are no internal stalls.
- States:
  - `S_IDLE`: `o_ready`=1. Bytes without `i_sof` are consumed and dropped. A byte with `i_sof` is latched as byte0 → `S_B1`.
  - `S_B0`, `S_B1`, `S_B2`: expect the byte of that phase. Transitions B0→B1→B2→B0.
  - `S_DONE`: entered after the final pixel write. `o_ready`=0 for exactly one cycle, then → `S_IDLE`.
- Addressing: pixel index p = 0..2·COLS·ROWS_PER_BANK−1.
  - Bank = p ≥ COLS·ROWS_PER_BANK. `o_ram_addr` = p mod (COLS·ROWS_PER_BANK), which equals row·COLS+col within the bank and matches the driver's linear scan.
  - Implemented as an address counter plus a bank bit. When the counter reaches COLS·ROWS_PER_BANK−1, it wraps to 0 and the bank bit sets.
- The final pixel is index 3071 with defaults. It is always pixel 1 of a triple, because the frame is 4608 bytes.
- SOF in `S_B0`/`S_B1`/`S_B2`: the partial frame is abandoned. The byte becomes byte0 of a new frame, the address and bank reset, `o_sync_err` pulses, and any half-assembled pixel is discarded with no write. SOF on byte0 of a frame, when not mid-frame, is legal and raises no error.
- SOF on the byte accepted in `S_DONE` cannot occur, because `o_ready`=0 there.
- Reset at any point: state→`S_IDLE`, counters→0, bank→1, and all outputs go to their reset values. A partially written frame stays in RAM.

## Timing
- Reset values: `o_ready`=1, `o_ram_addr`=0, `o_ram_data`=0, both `_we`=0, `o_frame_done`=0, `o_sync_err`=0.
- All outputs are registered. The write strobe, address and data appear the cycle after the accepting edge of byte1/byte2, and are held valid for that one cycle only.
- Exactly one of `o_ram_b1_we`/`o_ram_b2_we` is high per write. The strobes are never simultaneous.
- `o_frame_done` is asserted in the same cycle as the final write strobe.
- `o_ready` is low in the cycle `o_frame_done` is high. It is combinationally independent of `i_valid`.
- `o_sync_err` is asserted the cycle after the offending SOF byte is accepted.
- Back-to-back bytes are sustained at 1 byte/cycle. Idle cycles (`i_valid`=0) between bytes hold the state.

## Structure
- Shared package `led_matrix_pkg`: COLS, ROWS_PER_BANK, PIX_W, ADDR_W, RGB field offsets (R=8, G=4, B=0) and the bank size constant. The same package is used by the panel driver so both ends agree on layout.
- One sub-module, `fb_addr_gen`: address counter with bank bit. Interface: advance strobe, clear, `o_addr`, `o_bank`, `o_last`.
- Top level: handshake, byte-phase FSM and pixel assembly.

## Test plan
- Full frame, SOF on byte0, 4608 bytes back-to-back:
  - 3072 writes total: 1536 on b1 (addr 0..1535), then 1536 on b2 (addr 0..1535).
  - `o_frame_done` is a single pulse with the last b2 write at addr 1535.
  - `o_ready` is low for 1 cycle.
- Bytes 0xAB,0xCD,0xEF:
  - Write 1: `o_ram_data`=0xABC at addr 0.
  - Write 2: `o_ram_data`=0xDEF at addr 1.
  - Each write occurs 1 cycle after acceptance.
- Boundary: pixel 1535 is written to b1 addr 1535, and the next pixel is written to b2 addr 0.
- Idle dropping: 5 bytes without SOF in `S_IDLE` → no writes, `o_ready` stays 1. A following SOF frame starts at b1 addr 0.
- Mid-frame resync: SOF arrives in phase B2 after 100 bytes:
  - `o_sync_err` pulses once and no write occurs for the abandoned pixel.
  - The next writes start at b1 addr 0.
- Reset mid-frame with `i_rst`=1 for 1 cycle at byte 2000 → all outputs at reset values, and a new SOF frame writes b1 addr 0 first. Random `i_valid` gaps give results identical to the back-to-back case.
